// File: rtl/uart_mmio_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Word offsets, decoded from a[3:2]
  localparam logic [1:0] TXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] CTRL_OFS   = 2'd2;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;
  localparam int unsigned ST_COUNT = 8;

  localparam int unsigned CTRL_EN  = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; push when full and
// pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-attached 8N1 UART transmitter: address decode, control/status registers,
// TX FIFO and serializer FSM.
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADR     = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [1:0]       ofs;
  logic             wr_txdata, wr_status, wr_ctrl;
  logic             enable_q, overflow_q;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  tx_state_t        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             baud_end;
  logic             unused_bits;

  assign unused_bits = ^{wd[31:8], a[1:0]};

  // Address decode
  assign sel       = (a[31:4] == BASE_ADR[31:4]);
  assign ofs       = a[3:2];
  assign wr_txdata = we & sel & (ofs == TXDATA_OFS);
  assign wr_status = we & sel & (ofs == STATUS_OFS);
  assign wr_ctrl   = we & sel & (ofs == CTRL_OFS);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control and sticky overflow; a drop is judged on pre-edge fullness
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ctrl) enable_q <= wd[CTRL_EN];
      if (wr_txdata && fifo_full)      overflow_q <= 1'b1;
      else if (wr_status && wd[ST_OVF]) overflow_q <= 1'b0;
    end
  end

  // Combinational read path
  always_comb begin
    rd = '0;
    if (sel) begin
      unique case (ofs)
        STATUS_OFS: begin
          rd[ST_FULL]            = fifo_full;
          rd[ST_EMPTY]           = fifo_empty;
          rd[ST_BUSY]            = (state_q != IDLE);
          rd[ST_OVF]             = overflow_q;
          rd[ST_COUNT +: CNT_W]  = fifo_count;
        end
        CTRL_OFS: rd[CTRL_EN] = enable_q;
        default:  rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // Serializer next state; tx is derived from the next state so it is a flop
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (enable_q && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bit_d    = '0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a, wd, rd;
  logic        sel, tx;

  int checks = 0;
  int failures = 0;

  uart_tx_mmio #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8),
    .BASE_ADR     (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected tx waveform, one entry per cycle, index 0 = first cycle after pop
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      int k = i / 4;
      if (k == 0)      f[i] = 1'b0;
      else if (k == 9) f[i] = 1'b1;
      else             f[i] = b[k-1];
    end
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the write edge
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    we = 1'b0; a = A_ST; wd = '0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    check(tag, 64'(rd), 64'(exp));
  endtask

  task automatic capture(input int n, output logic [39:0] obs, output logic [39:0] bsy);
    obs = '0; bsy = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs[i] = tx;
      bsy[i] = rd[2];
    end
  endtask

  logic [39:0]  obs, bsy;
  logic [119:0] obs3;
  logic         all_high;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; we = 1'b0; a = A_ST; wd = '0;
    #3 reset = 1'b1;
    #1 check("reset_tx", 64'(tx), 64'd1);
    repeat (2) @(negedge clk);
    rd_check("reset_status", A_ST, 32'h0000_0002);
    check("reset_sel", 64'(sel), 64'd1);
    rd_check("reset_ctrl", A_CT, 32'h0000_0001);
    reset = 1'b0;
    a = A_ST;
    repeat (2) @(negedge clk);

    // Single byte
    wr(A_TX, 32'h55);
    capture(40, obs, bsy);
    check("single_frame", 64'(obs), 64'(frame_bits(8'h55)));
    check("single_busy", 64'(bsy), {24'd0, 40'hFF_FFFF_FFFF});
    @(negedge clk);
    check("single_idle_tx", 64'(tx), 64'd1);
    rd_check("single_idle_status", A_ST, 32'h0000_0002);
    repeat (3) @(negedge clk);

    // Back-to-back on consecutive cycles
    we = 1'b1; a = A_TX; wd = 32'hA5;
    @(negedge clk);
    wd = 32'h3C;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 0) wd = 32'hFF;
      if (i == 1) begin we = 1'b0; a = A_ST; wd = '0; end
      obs3[i] = tx;
    end
    check("b2b_frame0", 64'(obs3[39:0]),   64'(frame_bits(8'hA5)));
    check("b2b_frame1", 64'(obs3[79:40]),  64'(frame_bits(8'h3C)));
    check("b2b_frame2", 64'(obs3[119:80]), 64'(frame_bits(8'hFF)));
    @(negedge clk);
    rd_check("b2b_done_status", A_ST, 32'h0000_0002);
    repeat (2) @(negedge clk);

    // Overflow with transmitter disabled
    wr(A_CT, 32'h0);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'(i));
    rd_check("ovf_status", A_ST, 32'h0000_0809);
    check("ovf_tx_idle", 64'(tx), 64'd1);
    wr(A_ST, 32'h8);
    rd_check("ovf_cleared", A_ST, 32'h0000_0801);
    wr(A_CT, 32'h1);
    for (int f = 0; f < 8; f++) begin
      capture(40, obs, bsy);
      check($sformatf("ovf_drain%0d", f), 64'(obs), 64'(frame_bits(8'(f))));
    end
    @(negedge clk);
    rd_check("ovf_drained", A_ST, 32'h0000_0002);
    repeat (2) @(negedge clk);

    // Reset mid-frame with a second byte queued
    wr(A_TX, 32'h00);
    wr(A_TX, 32'h22);
    repeat (14) @(negedge clk);
    check("midreset_pre_tx", 64'(tx), 64'd0);
    reset = 1'b1;
    #1 check("midreset_tx", 64'(tx), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    all_high = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      all_high &= tx;
    end
    check("midreset_no_frames", 64'(all_high), 64'd1);
    rd_check("midreset_status", A_ST, 32'h0000_0002);

    // Decode
    we = 1'b1; a = BASE + 32'h10; wd = 32'h41;
    #1;
    check("dec_out_sel", 64'(sel), 64'd0);
    check("dec_out_rd", 64'(rd), 64'd0);
    @(negedge clk);
    we = 1'b0; a = A_ST; wd = '0;
    all_high = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      all_high &= tx;
    end
    check("dec_out_no_frame", 64'(all_high), 64'd1);
    rd_check("dec_out_status", A_ST, 32'h0000_0002);
    a = BASE + 32'hC;
    #1;
    check("dec_rsvd_sel", 64'(sel), 64'd1);
    check("dec_rsvd_rd", 64'(rd), 64'd0);
    @(negedge clk);
    wr(BASE + 32'h3, 32'h0000_1281);
    capture(40, obs, bsy);
    check("dec_unaligned_frame", 64'(obs), 64'(frame_bits(8'h81)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that sits on the single-cycle core's data-memory bus as a responder, alongside the data memory. The core stores bytes to a TX data register. They are queued in a small FIFO and serialized 8N1, LSB first, on `tx`. Reads return status/control combinationally in the same cycle, as the single-cycle load path requires; the top level muxes `rd` into `ReadData` when `sel` is high.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, 2..16.
- `BASE_ADR`, default 32'hFFFF_0000: register block base; bits [3:0] must be 0.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `we`  in  1: store strobe from core (`MemWrite`).
- `a`  in  32: byte address (`DataAdr`).
- `wd`  in  32: store data (`WriteData`).
- `rd`  out  32: combinational read data; 0 when `sel`=0.
- `sel`  out  1: combinational; 1 when `a[31:4]` == `BASE_ADR[31:4]`, regardless of `we`.
- `tx`  out  1: registered serial output; idles high.

## Operation
Register map. Offsets are selected by `a[3:2]`; `a[1:0]` is ignored.
- 0x0 TXDATA:
  - Write pushes `wd[7:0]` into the FIFO.
  - Reads 0.
- 0x4 STATUS, read:
  - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
  - bits [8 +: $clog2(FIFO_DEPTH)+1] = FIFO count; other bits 0.
- 0x4 STATUS, write: bit3 is write-1-to-clear; other bits ignored.
- 0x8 CTRL: bit0 enable, read/write; reset value 1.
- 0xC: reserved; reads 0, writes ignored.

Writes:
- A write takes effect on the rising edge where `we`=1 and `sel`=1.
- A TXDATA write while full (full as sampled before the edge) is dropped and sets overflow. This holds even if the FSM pops in the same cycle.
- Push into an empty FIFO in the same cycle the FSM samples it: the FSM sees empty and pops on the next cycle.

FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx`=1. If enable=1 and FIFO not empty: pop into the 8-bit shifter, clear the bit counter, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shifter[0] for CLKS_PER_BIT cycles per bit, shifting right. After bit 7, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if enable=1 and FIFO not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Clearing enable mid-frame lets the current frame finish; no new pop occurs.

Counters:
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps.
- Bit counter is 3 bits.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; the count is one bit wider.

Reset values, applied asynchronously:
- `tx`=1; FSM=IDLE.
- FIFO empty, count 0.
- overflow=0, enable=1.
- Baud and bit counters 0.
- Reset mid-frame aborts the frame immediately.

## Timing
- Write latency: a TXDATA write at edge N (FIFO was empty, FSM IDLE, enabled) pops at edge N+1. `tx` falls after edge N+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames are contiguous.
- `busy` is high from the pop edge until the edge at which STOP exits to IDLE.
- `rd` and `sel` are purely combinational from `a` and the current register/FIFO state. Status reflects pre-edge state within a cycle.
- `tx` is driven from a flop; no combinational path from the bus to `tx`.

## Structure
- Package `uart_mmio_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Register offset constants (`TXDATA_OFS`, `STATUS_OFS`, `CTRL_OFS`).
  - STATUS bit positions.
- Sub-module `sync_fifo`:
  - Parameterized WIDTH/DEPTH.
  - Ports: push/pop/din/dout/full/empty/count.
  - Asynchronous active-high reset.
  - First-word-fall-through `dout`.
- `uart_tx_mmio` contains the address decode, register file, and TX FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- **Reset:** assert `reset` between edges → `tx`=1 immediately; read BASE+0x4 → `rd`=0x0000_0002, `sel`=1; read BASE+0x8 → 0x1.
- **Single byte:** write 0x55 to BASE+0x0 → `tx` low for cycles 1–4 after the next edge, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. Frame is 40 cycles; busy=1 throughout, 0 after.
- **Back-to-back:** write 0xA5, 0x3C, 0xFF on consecutive cycles → three frames, 120 contiguous cycles, no high gap between STOP and the next START. Data LSB first.
- **Overflow:**
  - Write CTRL=0, then 9 TXDATA writes 0x00..0x08 → STATUS = full, overflow, count 8 (0x0000_0809).
  - Write STATUS=0x8 → overflow clears (0x0000_0801).
  - Write CTRL=1 → bytes 0x00..0x07 sent in order.
- **Reset mid-frame:** pulse `reset` 15 cycles into a frame with 2 bytes queued → `tx`=1 at once, STATUS=0x2, no further frames.
- **Decode:**
  - Write to BASE+0x10 → `sel`=0, no frame, `rd`=0.
  - Read BASE+0xC → `sel`=1, `rd`=0.
  - Write to BASE+0x3 (`a[1:0]`≠0) → treated as TXDATA.
